// File: rtl/ps2_keyboard_evq.sv
// ps2_keyboard_evq
//   PS/2 keyboard receiver. Deframes 11-bit PS/2 frames (start, 8 data LSB
//   first, odd parity, stop), folds E0 (extended) and F0 (break) prefixes
//   into single key events and queues them in a FIFO drained through a
//   valid/ready port.
//
//   Optional build macro: PS2_ASCII_EN -- when defined, ev_ascii carries the
//   scan-code set 2 ASCII translation of the head entry; otherwise it is 0.
//
// Ports
//   clk, resetn          system clock, synchronous active-low reset
//   ps2_clk, ps2_data    raw asynchronous PS/2 pins
//   ev_ready             consumer pops the head when ev_valid & ev_ready
//   ovf_clr              clears the sticky overflow flag
//   ev_valid             FIFO non-empty
//   ev_code/break/ext    head event fields (all 0 when empty)
//   ev_ascii             ASCII of head (0 when unmapped/extended/empty)
//   fifo_count           entries held, 0..FIFO_DEPTH
//   frame_err            one-cycle pulse on a bad frame or mid-frame timeout
//   overflow             sticky: an event was dropped on a full FIFO
module ps2_keyboard_evq #(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 3,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          ev_ready,
    input  logic                          ovf_clr,
    output logic                          ev_valid,
    output logic [7:0]                    ev_code,
    output logic                          ev_break,
    output logic                          ev_ext,
    output logic [7:0]                    ev_ascii,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_RELOAD = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    // Synchronisers idle high so reset never manufactures a falling edge.
    logic [SYNC_STAGES-1:0] csync_q;
    logic [1:0]             dsync_q;
    logic                   strobe, dbit;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [7:0]     data_q, data_d;
    logic           par_q, par_d, stop_q, stop_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           ext_q, ext_d, brk_q, brk_d;
    logic           push_req;

    logic [9:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic           ovf_q, ovf_d;
    logic           full, pop, push_ok, drop;
    logic [9:0]     head;

    assign strobe = csync_q[SYNC_STAGES-1] & ~csync_q[SYNC_STAGES-2];
    assign dbit   = dsync_q[1];

    // Frame FSM, timeout and prefix folding
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        par_d     = par_q;
        stop_d    = stop_q;
        tmo_d     = tmo_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        push_req  = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (strobe) begin
                    if (!dbit) begin
                        state_d = RECV;
                        cnt_d   = 4'd1;
                        tmo_d   = TMO_RELOAD;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
            end
            RECV: begin
                if (strobe) begin
                    tmo_d = TMO_RELOAD;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q <= 4'd8) begin
                        data_d = {dbit, data_q[7:1]};
                    end else if (cnt_q == 4'd9) begin
                        par_d = dbit;
                    end else begin
                        stop_d  = dbit;
                        state_d = CHECK;
                    end
                end else if (tmo_q == '0) begin
                    frame_err = 1'b1;
                    state_d   = IDLE;
                    ext_d     = 1'b0;
                    brk_d     = 1'b0;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
            end
            CHECK: begin
                state_d = IDLE;
                if ((^{data_q, par_q}) && stop_q) begin
                    if (data_q == 8'hE0) begin
                        ext_d = 1'b1;
                    end else if (data_q == 8'hF0) begin
                        brk_d = 1'b1;
                    end else begin
                        // Flags clear even when the push is dropped on overflow.
                        push_req = 1'b1;
                        ext_d    = 1'b0;
                        brk_d    = 1'b0;
                    end
                end else begin
                    frame_err = 1'b1;
                    ext_d     = 1'b0;
                    brk_d     = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO control
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign pop     = ev_valid & ev_ready;
    assign push_ok = push_req & (~full | pop);
    assign drop    = push_req & full & ~pop;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop)      count_d = count_q + CW'(1);
        else if (!push_ok && pop) count_d = count_q - CW'(1);
        ovf_d = ovf_q;
        if (drop)         ovf_d = 1'b1;   // a new drop beats a same-cycle clear
        else if (ovf_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            csync_q  <= '1;
            dsync_q  <= '1;
            state_q  <= IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            par_q    <= 1'b0;
            stop_q   <= 1'b0;
            tmo_q    <= '0;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            csync_q  <= {csync_q[SYNC_STAGES-2:0], ps2_clk};
            dsync_q  <= {dsync_q[0], ps2_data};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            par_q    <= par_d;
            stop_q   <= stop_d;
            tmo_q    <= tmo_d;
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // Storage needs no reset: entries are masked by ev_valid.
    always_ff @(posedge clk) begin
        if (resetn && push_ok) mem_q[wr_ptr_q] <= {brk_q, ext_q, data_q};
    end

    assign head       = mem_q[rd_ptr_q];
    assign ev_valid   = (count_q != '0);
    assign ev_code    = ev_valid ? head[7:0] : 8'h00;
    assign ev_ext     = ev_valid & head[8];
    assign ev_break   = ev_valid & head[9];
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

`ifdef PS2_ASCII_EN
    function automatic logic [7:0] set2_ascii(input logic [7:0] c);
        case (c)
            8'h1C: return 8'h61; 8'h32: return 8'h62; 8'h21: return 8'h63;
            8'h23: return 8'h64; 8'h24: return 8'h65; 8'h2B: return 8'h66;
            8'h34: return 8'h67; 8'h33: return 8'h68; 8'h43: return 8'h69;
            8'h3B: return 8'h6A; 8'h42: return 8'h6B; 8'h4B: return 8'h6C;
            8'h3A: return 8'h6D; 8'h31: return 8'h6E; 8'h44: return 8'h6F;
            8'h4D: return 8'h70; 8'h15: return 8'h71; 8'h2D: return 8'h72;
            8'h1B: return 8'h73; 8'h2C: return 8'h74; 8'h3C: return 8'h75;
            8'h2A: return 8'h76; 8'h1D: return 8'h77; 8'h22: return 8'h78;
            8'h35: return 8'h79; 8'h1A: return 8'h7A;
            8'h45: return 8'h30; 8'h16: return 8'h31; 8'h1E: return 8'h32;
            8'h26: return 8'h33; 8'h25: return 8'h34; 8'h2E: return 8'h35;
            8'h36: return 8'h36; 8'h3D: return 8'h37; 8'h3E: return 8'h38;
            8'h46: return 8'h39;
            8'h29: return 8'h20; 8'h5A: return 8'h0D; 8'h66: return 8'h08;
            default: return 8'h00;
        endcase
    endfunction

    assign ev_ascii = (ev_valid && !head[8]) ? set2_ascii(head[7:0]) : 8'h00;
`else
    assign ev_ascii = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_keyboard_evq.sv
module tb_ps2_keyboard_evq;
    localparam int DEPTH = 8;
    localparam int SS    = 3;
    localparam int TMO   = 300;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ev_ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       ev_valid, ev_break, ev_ext, frame_err, overflow;
    logic [7:0] ev_code, ev_ascii;
    logic [$clog2(DEPTH):0] fifo_count;

    int tests = 0;
    int fails = 0;
    int err_cnt = 0;
    int wide_err = 0;
    logic err_prev = 1'b0;
    logic lat_p3, lat_p4;

    ps2_keyboard_evq #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ev_ready(ev_ready), .ovf_clr(ovf_clr), .ev_valid(ev_valid), .ev_code(ev_code),
        .ev_break(ev_break), .ev_ext(ev_ext), .ev_ascii(ev_ascii), .fifo_count(fifo_count),
        .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Counts frame_err pulses and any pulse lasting more than one cycle.
    always @(negedge clk) begin
        if (frame_err) err_cnt <= err_cnt + 1;
        if (frame_err && err_prev) wide_err <= wide_err + 1;
        err_prev <= frame_err;
    end

    function automatic logic [7:0] exp_ascii(input logic [7:0] a);
`ifdef PS2_ASCII_EN
        return a;
`else
        return 8'h00 & a;
`endif
    endfunction

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    // Full frame; the stop bit is walked cycle by cycle so the push cycle is
    // known: strobe after the 2nd posedge, CHECK after the 3rd, write at the 4th.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit pop_at_push);
        logic [9:0] f;
        f = {(~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 10; i++) send_bit(f[i]);
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        lat_p3 = ev_valid;
        if (pop_at_push) ev_ready = 1'b1;
        @(negedge clk);
        lat_p4 = ev_valid;
        ev_ready = 1'b0;
        repeat (6) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic pop_one();
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({ev_valid, ev_code, ev_break, ev_ext, ev_ascii, fifo_count, frame_err, overflow} !== '0) begin
            fails++; $display("FAIL reset_outputs: got v=%b c=%h n=%0d ovf=%b, need all 0", ev_valid, ev_code, fifo_count, overflow);
        end
        resetn = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        send_frame(8'h1C, 0, 0);
        tests++;
        if (lat_p3 !== 1'b0 || lat_p4 !== 1'b1) begin
            fails++; $display("FAIL push_latency: got p3=%b p4=%b, need 0 1", lat_p3, lat_p4);
        end
        tests++;
        if (ev_valid !== 1'b1 || ev_code !== 8'h1C || ev_break !== 1'b0 || ev_ext !== 1'b0 || fifo_count !== 1) begin
            fails++; $display("FAIL basic_event: got v=%b c=%h b=%b e=%b n=%0d, need 1 1c 0 0 1", ev_valid, ev_code, ev_break, ev_ext, fifo_count);
        end
        tests++;
        if (ev_ascii !== exp_ascii(8'h61)) begin
            fails++; $display("FAIL basic_ascii: got %h need %h", ev_ascii, exp_ascii(8'h61));
        end
        pop_one();
        tests++;
        if ({ev_valid, ev_code, ev_break, ev_ext, ev_ascii, fifo_count} !== '0) begin
            fails++; $display("FAIL basic_pop_empty: got v=%b c=%h a=%h n=%0d, need 0", ev_valid, ev_code, ev_ascii, fifo_count);
        end
    endtask

    task automatic test_prefix();
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);
        tests++;
        if (fifo_count !== 1 || ev_code !== 8'h1C || ev_break !== 1'b1 || ev_ext !== 1'b0) begin
            fails++; $display("FAIL break_fold: got n=%0d c=%h b=%b e=%b, need 1 1c 1 0", fifo_count, ev_code, ev_break, ev_ext);
        end
        pop_one();
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h75, 0, 0);
        tests++;
        if (fifo_count !== 1 || ev_code !== 8'h75 || ev_break !== 1'b1 || ev_ext !== 1'b1 || ev_ascii !== 8'h00) begin
            fails++; $display("FAIL ext_break_fold: got n=%0d c=%h b=%b e=%b a=%h, need 1 75 1 1 00", fifo_count, ev_code, ev_break, ev_ext, ev_ascii);
        end
        pop_one();
    endtask

    task automatic test_parity();
        int e0;
        e0 = err_cnt;
        send_frame(8'h1C, 1, 0);
        tests++;
        if (err_cnt - e0 !== 1 || fifo_count !== 0) begin
            fails++; $display("FAIL parity_err: got errs=%0d n=%0d, need 1 0", err_cnt - e0, fifo_count);
        end
        send_frame(8'h23, 0, 0);
        tests++;
        if (ev_code !== 8'h23 || ev_ascii !== exp_ascii(8'h64) || fifo_count !== 1) begin
            fails++; $display("FAIL after_parity: got c=%h a=%h n=%0d, need 23 %h 1", ev_code, ev_ascii, fifo_count, exp_ascii(8'h64));
        end
        pop_one();
        send_frame(8'hF0, 0, 0);
        send_frame(8'h55, 1, 0);
        send_frame(8'h1C, 0, 0);
        tests++;
        if (ev_code !== 8'h1C || ev_break !== 1'b0 || fifo_count !== 1) begin
            fails++; $display("FAIL err_clears_brk: got c=%h b=%b n=%0d, need 1c 0 1", ev_code, ev_break, fifo_count);
        end
        pop_one();
    endtask

    task automatic test_overflow();
        logic [7:0] codes [10];
        codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
        for (int i = 0; i < DEPTH + 2; i++) send_frame(codes[i], 0, 0);
        tests++;
        if (fifo_count !== DEPTH || overflow !== 1'b1) begin
            fails++; $display("FAIL ovf_fill: got n=%0d ovf=%b, need %0d 1", fifo_count, overflow, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            tests++;
            if (ev_code !== codes[i]) begin
                fails++; $display("FAIL ovf_order[%0d]: got %h need %h", i, ev_code, codes[i]);
            end
            pop_one();
        end
        tests++;
        if (fifo_count !== 0 || overflow !== 1'b1) begin
            fails++; $display("FAIL ovf_drained: got n=%0d ovf=%b, need 0 1", fifo_count, overflow);
        end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        tests++;
        if (overflow !== 1'b0) begin
            fails++; $display("FAIL ovf_clr: got %b need 0", overflow);
        end
        for (int i = 0; i < DEPTH; i++) send_frame(codes[i], 0, 0);
        send_frame(8'h29, 0, 1);
        tests++;
        if (fifo_count !== DEPTH || overflow !== 1'b0 || ev_code !== codes[1]) begin
            fails++; $display("FAIL full_pop_push: got n=%0d ovf=%b c=%h, need %0d 0 %h", fifo_count, overflow, ev_code, DEPTH, codes[1]);
        end
        for (int i = 0; i < DEPTH - 1; i++) pop_one();
        tests++;
        if (ev_code !== 8'h29 || fifo_count !== 1) begin
            fails++; $display("FAIL full_pop_push_tail: got c=%h n=%0d, need 29 1", ev_code, fifo_count);
        end
        pop_one();
    endtask

    task automatic test_timeout();
        int e0, first;
        e0 = err_cnt;
        first = 0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ps2_data = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        for (int n = 1; n <= TMO + 10; n++) begin
            @(negedge clk);
            if (n == 10) ps2_clk = 1'b1;
            if (frame_err && first == 0) first = n;
        end
        tests++;
        if (first !== TMO + SS - 1 || err_cnt - e0 !== 1) begin
            fails++; $display("FAIL timeout: got at=%0d errs=%0d, need at=%0d errs=1", first, err_cnt - e0, TMO + SS - 1);
        end
        send_frame(8'h29, 0, 0);
        tests++;
        if (ev_code !== 8'h29 || ev_ascii !== exp_ascii(8'h20) || fifo_count !== 1) begin
            fails++; $display("FAIL after_timeout: got c=%h a=%h n=%0d, need 29 %h 1", ev_code, ev_ascii, fifo_count, exp_ascii(8'h20));
        end
        pop_one();
    endtask

    task automatic test_midframe_reset();
        logic [9:0] f;
        int e0;
        send_frame(8'h1C, 0, 0);
        f = {~^8'h5A, 8'h5A, 1'b0};
        for (int i = 0; i < 6; i++) send_bit(f[i]);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        tests++;
        if ({ev_valid, ev_code, ev_break, ev_ext, ev_ascii, fifo_count, frame_err, overflow} !== '0) begin
            fails++; $display("FAIL midframe_reset: got v=%b c=%h n=%0d err=%b, need all 0", ev_valid, ev_code, fifo_count, frame_err);
        end
        repeat (5) @(negedge clk);
        e0 = err_cnt;
        send_frame(8'h5A, 0, 0);
        tests++;
        if (ev_code !== 8'h5A || ev_ascii !== exp_ascii(8'h0D) || fifo_count !== 1 || err_cnt !== e0) begin
            fails++; $display("FAIL after_reset: got c=%h a=%h n=%0d errs=%0d, need 5a %h 1 0", ev_code, ev_ascii, fifo_count, err_cnt - e0, exp_ascii(8'h0D));
        end
        pop_one();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prefix();
        test_parity();
        test_overflow();
        test_timeout();
        test_midframe_reset();
        tests++;
        if (wide_err !== 0) begin
            fails++; $display("FAIL err_pulse_width: got %0d long pulses, need 0", wide_err);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
